// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetch stage after the registered program RAM; valid/ready to decode.
//            Optional macro FETCH_HALT_ON_ZERO_EN stops fetch on a zero word.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int          ADDR_W   = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [31:0] PC_add,
  input  logic [31:0] ram_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted
);

  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [31:0]       r_instr;
  logic [31:0]       r_instr_pc;
  logic              r_valid;
  logic              w_valid_next;
  logic              w_capture;
  logic              w_halt_word;

  // Only the low ADDR_W bits of the redirect target address the RAM.
  logic w_unused_redirect_hi;
  assign w_unused_redirect_hi = &{1'b0, redirect_pc[31:ADDR_W]};

  assign PC_add      = {{(32-ADDR_W){1'b0}}, r_pc};
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;

`ifdef FETCH_HALT_ON_ZERO_EN
  logic r_halted;
  logic w_halted_next;
  assign w_halt_word = (ram_data == 32'h0);
  assign halted      = r_halted;

  always_comb begin
    w_halted_next = r_halted;
    if (redirect)
      w_halted_next = 1'b0;
    else if (r_state == S_CAPTURE && run && w_halt_word)
      w_halted_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_halted <= 1'b0;
    else        r_halted <= w_halted_next;
  end
`else
  assign w_halt_word = 1'b0;
  assign halted      = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_valid_next = r_valid;
    w_capture    = 1'b0;
    if (redirect) begin
      // Any in-flight read or held word is abandoned, including one accepted this cycle.
      w_pc_next    = redirect_pc[ADDR_W-1:0];
      w_valid_next = 1'b0;
      w_state_next = run ? S_ISSUE : S_IDLE;
    end else if (!run && r_state != S_IDLE && r_state != S_HALT) begin
      w_valid_next = 1'b0;
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (run) w_state_next = S_ISSUE;
        S_ISSUE:   w_state_next = S_CAPTURE;
        S_CAPTURE: begin
          if (w_halt_word) begin
            w_state_next = S_HALT;
          end else begin
            w_capture    = 1'b1;
            w_valid_next = 1'b1;
            w_state_next = S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            w_pc_next    = r_pc + ADDR_W'(1);
            w_valid_next = 1'b0;
            w_state_next = S_ISSUE;
          end
        end
`ifdef FETCH_HALT_ON_ZERO_EN
        S_HALT:    w_state_next = S_HALT;
`else
        S_HALT:    w_state_next = S_IDLE;
`endif
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= C_RESET_PC;
      r_instr    <= 32'h0;
      r_instr_pc <= 32'h0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_valid <= w_valid_next;
      if (w_capture) begin
        r_instr    <= ram_data;
        r_instr_pc <= {{(32-ADDR_W){1'b0}}, r_pc};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed self-checking bench for instr_fetch with a registered RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] PC_add;
  logic [31:0] ram_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;

  logic [31:0] mem [0:31];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc;

  instr_fetch #(.ADDR_W(5), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .PC_add      (PC_add),
    .ram_data    (ram_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_data <= mem[PC_add[4:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Counts negedges until instr_valid is seen, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 20);
    if (!instr_valid) check("valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    redirect    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd0;

    rst_n = 1'b0; run = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc_add", PC_add, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid", 32'(instr_valid), 32'h0);
    check("idle_pc_add", PC_add, 32'h0);

    // Sequential fetch with ready held high
    run = 1'b1; instr_ready = 1'b1;
    wait_valid(cyc);
    check("lat_first", 32'(cyc), 32'd3);
    check("seq0_instr", instr, 32'd1);
    check("seq0_pc", instr_pc, 32'd0);
    wait_valid(cyc);
    check("thr_1", 32'(cyc), 32'd3);
    check("seq1_instr", instr, 32'd2);
    check("seq1_pc", instr_pc, 32'd1);
    wait_valid(cyc);
    check("thr_2", 32'(cyc), 32'd3);
    check("seq2_instr", instr, 32'd3);
    check("seq2_pc", instr_pc, 32'd2);

    // Backpressure in HOLD
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_instr", instr, 32'd3);
      check("bp_pc", instr_pc, 32'd2);
      check("bp_pc_add", PC_add, 32'd2);
    end
    instr_ready = 1'b1;

`ifdef FETCH_HALT_ON_ZERO_EN
    repeat (6) @(negedge clk);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_pc_add", PC_add, 32'd3);
    run = 1'b0;
    repeat (2) @(negedge clk);
    check("halt_run0", 32'(halted), 32'd1);
    run = 1'b1;
    do_redirect(32'h0);
    check("halt_clear", 32'(halted), 32'd0);
    wait_valid(cyc);
    check("halt_redir_lat", 32'(cyc), 32'd2);
    check("halt_redir_instr", instr, 32'd1);
    check("halt_redir_pc", instr_pc, 32'd0);
`else
    wait_valid(cyc);
    check("zero_lat", 32'(cyc), 32'd3);
    check("zero_instr", instr, 32'd0);
    check("zero_pc", instr_pc, 32'd3);
    check("zero_halted", 32'(halted), 32'd0);
`endif

    // Redirect during CAPTURE: word consumed above, then ISSUE, then CAPTURE
    repeat (2) @(negedge clk);
    do_redirect(32'h25);
    check("redir_discard", 32'(instr_valid), 32'd0);
    check("redir_pc_add", PC_add, 32'd5);
    wait_valid(cyc);
    check("redir_lat", 32'(cyc), 32'd2);
    check("redir_instr", instr, 32'h105);
    check("redir_pc", instr_pc, 32'd5);

    // Redirect together with handshake in HOLD
    do_redirect(32'd31);
    check("rhs_valid", 32'(instr_valid), 32'd0);
    check("rhs_pc_add", PC_add, 32'd31);
    wait_valid(cyc);
    check("rhs_instr", instr, 32'h11F);
    check("rhs_pc", instr_pc, 32'd31);

    // Wrap 31 -> 0
    wait_valid(cyc);
    check("wrap_lat", 32'(cyc), 32'd3);
    check("wrap_instr", instr, 32'd1);
    check("wrap_pc", instr_pc, 32'd0);

    // run=0 in HOLD drops the word; resume refetches same pc
    instr_ready = 1'b0; run = 1'b0;
    @(negedge clk);
    check("run0_valid", 32'(instr_valid), 32'd0);
    check("run0_pc_add", PC_add, 32'd0);
    repeat (2) @(negedge clk);
    check("run0_stay", 32'(instr_valid), 32'd0);
    run = 1'b1; instr_ready = 1'b1;
    wait_valid(cyc);
    check("resume_lat", 32'(cyc), 32'd3);
    check("resume_instr", instr, 32'd1);
    check("resume_pc", instr_pc, 32'd0);

    // Asynchronous reset while holding pc=1
    wait_valid(cyc);
    instr_ready = 1'b0;
    check("pre_rst_pc", instr_pc, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_pc_add", PC_add, 32'd0);
    check("arst_instr", instr, 32'd0);
    check("arst_instr_pc", instr_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
